// File: rtl/temp_pkg.sv
// Shared constants and FSM encoding for the temperature history
// reader and the writer-side controller.
package temp_pkg;

  localparam int DEPTH  = 10;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int SUM_W  = 12;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_DIVIDE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle.
// The first bit is produced on the start edge itself.
module seq_divider #(
  parameter int DVD_W = 12,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DVD_W-1:0] quot_o
);

  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVD_W-1:0] quot_q, quot_d;
  logic [3:0]       cnt_q;
  logic             run_q;
  logic             done_q;

  logic [DVS_W-1:0] src_r;
  logic [DVD_W-1:0] src_q;
  logic [DVS_W:0]   sh;
  logic [DVS_W:0]   dvs;
  logic [DVS_W:0]   diff;

  // One restoring step on either fresh operands or the running state
  always_comb begin
    src_r  = start_i ? '0 : rem_q;
    src_q  = start_i ? dividend_i : quot_q;
    sh     = {src_r, src_q[DVD_W-1]};
    dvs    = {1'b0, divisor_i};
    diff   = sh - dvs;
    rem_d  = sh[DVS_W-1:0];
    quot_d = {src_q[DVD_W-2:0], 1'b0};
    if (sh >= dvs) begin
      rem_d  = diff[DVS_W-1:0];
      quot_d = {src_q[DVD_W-2:0], 1'b1};
    end
  end

  // Iteration counter; done pulses the cycle the last bit is in place
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        cnt_q  <= 4'(DVD_W - 1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        cnt_q  <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/temp_stats_reader.sv
// Sweeps the temperature history BRAM and reports average,
// maximum and minimum of the valid slots.
module temp_stats_reader #(
  parameter int DEPTH  = temp_pkg::DEPTH,
  parameter int DATA_W = temp_pkg::DATA_W,
  parameter int ADDR_W = temp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] entry_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              stats_valid,
  output logic [DATA_W-1:0] avg_temp,
  output logic [DATA_W-1:0] max_temp,
  output logic [DATA_W-1:0] min_temp
);

  import temp_pkg::*;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] n_q, addr_q, n_clamp;
  logic              vld_q;
  logic [SUM_W-1:0]  sum_q, sum_nx, sum_fin;
  logic [DATA_W-1:0] max_q, min_q;
  logic [DATA_W-1:0] avg_o_q, max_o_q, min_o_q, avg_nx;
  logic              sv_q;
  logic              div_start, div_done;
  logic [SUM_W-1:0]  quot;
  logic              go;

  assign n_clamp = (entry_count > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH)
                                                  : entry_count;
  assign go      = (state_q == S_IDLE) && start;
  assign sum_nx  = sum_q + SUM_W'(rd_data);
  assign sum_fin = vld_q ? sum_nx : sum_q;
  assign div_start = (state_q == S_DRAIN);
  assign avg_nx  = (|quot[SUM_W-1:DATA_W]) ? '1 : quot[DATA_W-1:0];

  seq_divider #(
    .DVD_W(SUM_W),
    .DVS_W(ADDR_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .dividend_i(sum_fin),
    .divisor_i (n_q),
    .done_o    (div_done),
    .quot_o    (quot)
  );

  // Sweep sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = (n_clamp == '0) ? S_DONE : S_READ;
      S_READ:   if (addr_q == n_q - 1'b1) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_DIVIDE;
      S_DIVIDE: if (div_done) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, address, accumulators and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      avg_o_q <= '0;
      max_o_q <= '0;
      min_o_q <= '0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= (state_q == S_READ);
      if (go) begin
        n_q    <= n_clamp;
        addr_q <= '0;
        sum_q  <= '0;
        max_q  <= '0;
        min_q  <= '1;
        if (n_clamp == '0) begin
          avg_o_q <= '0;
          max_o_q <= '0;
          min_o_q <= '0;
          sv_q    <= 1'b0;
        end
      end else if (vld_q) begin
        sum_q <= sum_nx;
        if (rd_data > max_q) max_q <= rd_data;
        if (rd_data < min_q) min_q <= rd_data;
      end
      if (state_q == S_READ) begin
        addr_q <= (state_d == S_READ) ? addr_q + 1'b1 : '0;
      end
      if ((state_q == S_DIVIDE) && div_done) begin
        avg_o_q <= avg_nx;
        max_o_q <= max_q;
        min_o_q <= min_q;
        sv_q    <= 1'b1;
      end
    end
  end

  assign rd_en       = (state_q == S_READ);
  assign rd_addr     = addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign stats_valid = sv_q;
  assign avg_temp    = avg_o_q;
  assign max_temp    = max_o_q;
  assign min_temp    = min_o_q;

endmodule

// File: tb/tb_temp_stats_reader.sv
// Bench for temp_stats_reader: BRAM model with 1-cycle read
// latency and an arithmetic reference for the statistics.
module tb_temp_stats_reader;

  localparam int DEPTH  = 10;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] entry_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              stats_valid;
  logic [DATA_W-1:0] avg_temp;
  logic [DATA_W-1:0] max_temp;
  logic [DATA_W-1:0] min_temp;

  logic [DATA_W-1:0] mem [DEPTH];

  int checks = 0;
  int fails  = 0;

  int s_done_cyc, s_ndone, s_rd_cnt, s_max_addr;
  bit s_order_ok;
  logic [DATA_W-1:0] s_avg, s_max, s_min;
  logic s_sv;

  int e_avg, e_max, e_min, e_sv;

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  temp_stats_reader #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .entry_count(entry_count),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .stats_valid(stats_valid),
    .avg_temp   (avg_temp),
    .max_temp   (max_temp),
    .min_temp   (min_temp)
  );

  function automatic void model(input int n);
    int sum, mx, mn;
    sum = 0; mx = 0; mn = 255;
    for (int i = 0; i < n; i++) begin
      sum += int'(mem[i]);
      if (int'(mem[i]) > mx) mx = int'(mem[i]);
      if (int'(mem[i]) < mn) mn = int'(mem[i]);
    end
    if (n == 0) begin
      e_avg = 0; e_max = 0; e_min = 0; e_sv = 0;
    end else begin
      e_avg = sum / n; e_max = mx; e_min = mn; e_sv = 1;
    end
  endfunction

  function automatic int clampn(input int ec);
    return (ec > DEPTH) ? DEPTH : ec;
  endfunction

  task automatic load_spec_mem();
    int v [DEPTH] = '{20, 25, 30, 22, 18, 27, 24, 21, 19, 26};
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(v[i]);
  endtask

  // Start a sweep at edge 0 and observe cycles 1..60 mid-cycle
  task automatic sweep(input int ec, input bit extra);
    s_done_cyc = -1; s_ndone = 0; s_rd_cnt = 0;
    s_max_addr = 0; s_order_ok = 1'b1;
    s_avg = '0; s_max = '0; s_min = '0; s_sv = 1'b0;
    @(negedge clk);
    entry_count = ADDR_W'(ec);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (rd_en === 1'b1) begin
        if (rd_addr !== ADDR_W'(s_rd_cnt)) s_order_ok = 1'b0;
        if (int'(rd_addr) > s_max_addr) s_max_addr = int'(rd_addr);
        s_rd_cnt++;
      end
      if (done === 1'b1) begin
        s_ndone++;
        if (s_done_cyc < 0) begin
          s_done_cyc = c;
          s_avg = avg_temp; s_max = max_temp;
          s_min = min_temp; s_sv = stats_valid;
        end
      end
      if (extra && c == 3) start = 1'b1;
      if (extra && c == 4) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; entry_count = '0;
    repeat (3) @(negedge clk);
    start = 1'b1; entry_count = 4'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl busy=%b done=%b rd_en=%b want 000",
               busy, done, rd_en);
    end
    checks++;
    if (rd_addr !== '0 || stats_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_addr rd_addr=%0d sv=%b want 0 0",
               rd_addr, stats_valid);
    end
    checks++;
    if (avg_temp !== '0 || max_temp !== '0 || min_temp !== '0) begin
      fails++;
      $display("FAIL reset_out avg=%0d max=%0d min=%0d want 0",
               avg_temp, max_temp, min_temp);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_prio busy=%b want 0", busy);
    end
  endtask

  task automatic test_full();
    load_spec_mem();
    sweep(10, 1'b0);
    checks++;
    if (s_done_cyc != 24 || s_ndone != 1) begin
      fails++;
      $display("FAIL full_lat cyc=%0d n=%0d want 24 1",
               s_done_cyc, s_ndone);
    end
    checks++;
    if (s_avg !== 8'd23 || s_max !== 8'd30 || s_min !== 8'd18) begin
      fails++;
      $display("FAIL full_res avg=%0d max=%0d min=%0d want 23 30 18",
               s_avg, s_max, s_min);
    end
    checks++;
    if (s_sv !== 1'b1 || s_rd_cnt != 10 || !s_order_ok) begin
      fails++;
      $display("FAIL full_rd sv=%b reads=%0d ord=%0d want 1 10 1",
               s_sv, s_rd_cnt, s_order_ok);
    end
    checks++;
    if (avg_temp !== 8'd23 || min_temp !== 8'd18 || done !== 1'b0) begin
      fails++;
      $display("FAIL full_hold avg=%0d min=%0d done=%b want 23 18 0",
               avg_temp, min_temp, done);
    end
  endtask

  task automatic test_partial();
    load_spec_mem();
    sweep(3, 1'b0);
    checks++;
    if (s_done_cyc != 17 || s_rd_cnt != 3 || s_max_addr != 2) begin
      fails++;
      $display("FAIL part_rd cyc=%0d reads=%0d maxa=%0d want 17 3 2",
               s_done_cyc, s_rd_cnt, s_max_addr);
    end
    checks++;
    if (s_avg !== 8'd25 || s_max !== 8'd30 || s_min !== 8'd20) begin
      fails++;
      $display("FAIL part_res avg=%0d max=%0d min=%0d want 25 30 20",
               s_avg, s_max, s_min);
    end
  endtask

  task automatic test_zero();
    sweep(0, 1'b0);
    checks++;
    if (s_done_cyc != 1 || s_ndone != 1 || s_rd_cnt != 0) begin
      fails++;
      $display("FAIL zero_lat cyc=%0d n=%0d reads=%0d want 1 1 0",
               s_done_cyc, s_ndone, s_rd_cnt);
    end
    checks++;
    if (s_avg !== '0 || s_max !== '0 || s_min !== '0 || s_sv !== 1'b0) begin
      fails++;
      $display("FAIL zero_out avg=%0d max=%0d min=%0d sv=%b want 0",
               s_avg, s_max, s_min, s_sv);
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd255;
    sweep(15, 1'b0);
    checks++;
    if (s_rd_cnt != 10 || s_max_addr != 9 || s_done_cyc != 24) begin
      fails++;
      $display("FAIL clamp_rd reads=%0d maxa=%0d cyc=%0d want 10 9 24",
               s_rd_cnt, s_max_addr, s_done_cyc);
    end
    checks++;
    if (s_avg !== 8'd255 || s_max !== 8'd255 || s_min !== 8'd255) begin
      fails++;
      $display("FAIL clamp_res avg=%0d max=%0d min=%0d want 255",
               s_avg, s_max, s_min);
    end
  endtask

  task automatic test_abort();
    int nd;
    load_spec_mem();
    @(negedge clk);
    entry_count = 4'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || stats_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_ctl busy=%b rd_en=%b sv=%b want 000",
               busy, rd_en, stats_valid);
    end
    checks++;
    if (avg_temp !== '0 || max_temp !== '0 || min_temp !== '0) begin
      fails++;
      $display("FAIL abort_out avg=%0d max=%0d min=%0d want 0",
               avg_temp, max_temp, min_temp);
    end
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    checks++;
    if (nd != 0) begin
      fails++;
      $display("FAIL abort_done pulses=%0d want 0", nd);
    end
    sweep(10, 1'b0);
    checks++;
    if (s_done_cyc != 24 || s_avg !== 8'd23 || s_sv !== 1'b1) begin
      fails++;
      $display("FAIL abort_rerun cyc=%0d avg=%0d sv=%b want 24 23 1",
               s_done_cyc, s_avg, s_sv);
    end
  endtask

  task automatic test_back_to_back();
    load_spec_mem();
    sweep(10, 1'b1);
    checks++;
    if (s_ndone != 1 || s_done_cyc != 24 || s_rd_cnt != 10) begin
      fails++;
      $display("FAIL b2b_done n=%0d cyc=%0d reads=%0d want 1 24 10",
               s_ndone, s_done_cyc, s_rd_cnt);
    end
    checks++;
    if (s_avg !== 8'd23 || s_max !== 8'd30 || s_min !== 8'd18) begin
      fails++;
      $display("FAIL b2b_res avg=%0d max=%0d min=%0d want 23 30 18",
               s_avg, s_max, s_min);
    end
  endtask

  task automatic test_random();
    int ec, n;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
      ec = int'($urandom_range(0, 15));
      n = clampn(ec);
      model(n);
      sweep(ec, 1'b0);
      checks++;
      if (s_done_cyc != ((n == 0) ? 1 : n + 14) || s_ndone != 1) begin
        fails++;
        $display("FAIL rnd_lat t=%0d ec=%0d cyc=%0d n=%0d want %0d 1",
                 t, ec, s_done_cyc, s_ndone, (n == 0) ? 1 : n + 14);
      end
      checks++;
      if (s_rd_cnt != n || !s_order_ok) begin
        fails++;
        $display("FAIL rnd_rd t=%0d reads=%0d ord=%0d want %0d 1",
                 t, s_rd_cnt, s_order_ok, n);
      end
      checks++;
      if (s_avg !== 8'(e_avg) || s_max !== 8'(e_max) ||
          s_min !== 8'(e_min) || s_sv !== 1'(e_sv)) begin
        fails++;
        $display("FAIL rnd_res t=%0d got %0d/%0d/%0d/%b want %0d/%0d/%0d/%0d",
                 t, s_avg, s_max, s_min, s_sv, e_avg, e_max, e_min, e_sv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_partial();
    test_zero();
    test_clamp();
    test_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
